// File: rtl/wb_bridge_arbiter.sv
// wb_bridge_arbiter: two-master round-robin Wishbone arbiter in front of a shared UART-bridge slave.
// Ports:
//   clock, reset                      posedge clock, synchronous active-high reset
//   m0_*/m1_* cyc stb we adr datwr sel master requests
//   m0_*/m1_* datrd ack err           master responses (err is a one-cycle timeout pulse)
//   s_* cyc stb we adr datwr sel      shared slave request, mirrors the owner while BUSY
//   s_datrd, s_ack                    slave response, routed to the owner only
//   gnt                               one-hot owner, 00 when the bus is free
module wb_bridge_arbiter #(
    parameter int          addr_width     = 4,
    parameter int          data_width     = 8,
    parameter int          sel_width      = 1,
    parameter int unsigned timeout_cycles = 65535
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  m0_cyc,
    input  logic                  m1_cyc,
    input  logic                  m0_stb,
    input  logic                  m1_stb,
    input  logic                  m0_we,
    input  logic                  m1_we,
    input  logic [addr_width-1:0] m0_adr,
    input  logic [addr_width-1:0] m1_adr,
    input  logic [data_width-1:0] m0_datwr,
    input  logic [data_width-1:0] m1_datwr,
    input  logic [sel_width-1:0]  m0_sel,
    input  logic [sel_width-1:0]  m1_sel,
    output logic [data_width-1:0] m0_datrd,
    output logic [data_width-1:0] m1_datrd,
    output logic                  m0_ack,
    output logic                  m1_ack,
    output logic                  m0_err,
    output logic                  m1_err,
    output logic                  s_cyc,
    output logic                  s_stb,
    output logic                  s_we,
    output logic [addr_width-1:0] s_adr,
    output logic [data_width-1:0] s_datwr,
    output logic [sel_width-1:0]  s_sel,
    input  logic [data_width-1:0] s_datrd,
    input  logic                  s_ack,
    output logic [1:0]            gnt
);
    typedef enum logic [1:0] {IDLE, BUSY, DRAIN} state_t;
    localparam logic [31:0] tmo_last = 32'(timeout_cycles) - 32'd1;
    state_t      r_state;
    logic        r_owner;
    logic        r_last;
    logic [1:0]  r_gnt;
    logic [1:0]  r_err;
    logic [31:0] r_timer;
    logic                  w_req0, w_req1, w_win, w_busy, w_drain, w_tmo;
    logic                  w_own_cyc, w_own_stb, w_own_we;
    logic [addr_width-1:0] w_own_adr;
    logic [data_width-1:0] w_own_datwr;
    logic [sel_width-1:0]  w_own_sel;
    assign w_req0      = m0_cyc & m0_stb;
    assign w_req1      = m1_cyc & m1_stb;
    // on a tie the master that did not win last time gets the bus
    assign w_win       = (w_req0 & w_req1) ? ~r_last : w_req1;
    assign w_busy      = r_state == BUSY;
    assign w_drain     = r_state == DRAIN;
    assign w_own_cyc   = r_owner ? m1_cyc : m0_cyc;
    assign w_own_stb   = r_owner ? m1_stb : m0_stb;
    assign w_own_we    = r_owner ? m1_we : m0_we;
    assign w_own_adr   = r_owner ? m1_adr : m0_adr;
    assign w_own_datwr = r_owner ? m1_datwr : m0_datwr;
    assign w_own_sel   = r_owner ? m1_sel : m0_sel;
    assign w_tmo       = (timeout_cycles != 0) && (r_timer == tmo_last) && !s_ack;
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
            r_owner <= 1'b0;
            r_last  <= 1'b1;
            r_gnt   <= 2'b00;
            r_err   <= 2'b00;
            r_timer <= '0;
        end else begin
            r_err <= 2'b00;
            case (r_state)
                IDLE:
                    if (w_req0 | w_req1) begin
                        r_state <= BUSY;
                        r_owner <= w_win;
                        r_last  <= w_win;
                        r_gnt   <= w_win ? 2'b10 : 2'b01;
                        r_timer <= '0;
                    end
                BUSY:
                    if (!w_own_cyc) begin
                        r_state <= IDLE;
                        r_gnt   <= 2'b00;
                    end else if (s_ack) begin
                        r_timer <= '0;
                    end else if (w_tmo) begin
                        r_state <= DRAIN;
                        r_err   <= r_owner ? 2'b10 : 2'b01;
                    end else if (w_own_stb && r_timer != '1) begin
                        r_timer <= r_timer + 32'd1;
                    end
                // hold the slave cycle open until the abandoned transfer's ack arrives
                DRAIN:
                    if (s_ack) begin
                        r_state <= IDLE;
                        r_gnt   <= 2'b00;
                    end
                default: r_state <= IDLE;
            endcase
        end
    end
    assign s_cyc    = w_busy ? w_own_cyc : w_drain;
    assign s_stb    = w_busy & w_own_stb;
    assign s_we     = w_busy & w_own_we;
    assign s_adr    = w_busy ? w_own_adr : '0;
    assign s_datwr  = w_busy ? w_own_datwr : '0;
    assign s_sel    = w_busy ? w_own_sel : '0;
    assign m0_ack   = w_busy & ~r_owner & s_ack;
    assign m1_ack   = w_busy & r_owner & s_ack;
    assign m0_datrd = (w_busy & ~r_owner) ? s_datrd : '0;
    assign m1_datrd = (w_busy & r_owner) ? s_datrd : '0;
    assign m0_err   = r_err[0];
    assign m1_err   = r_err[1];
    assign gnt      = r_gnt;
endmodule

// File: tb/tb_wb_bridge_arbiter.sv
// tb_wb_bridge_arbiter: directed vectors plus timeout/reset/stall sequences for wb_bridge_arbiter.
module tb_wb_bridge_arbiter;
    logic clock = 1'b0;
    logic reset = 1'b1;
    logic m0_cyc = 0, m1_cyc = 0, m0_stb = 0, m1_stb = 0, s_ack = 0;
    logic m0_we = 1'b0, m1_we = 1'b1;
    logic [3:0] m0_adr = 4'h3, m1_adr = 4'hA;
    logic [7:0] m0_datwr = 8'h11, m1_datwr = 8'h22, s_datrd = 8'h5A;
    logic [0:0] m0_sel = 1'b1, m1_sel = 1'b1;
    logic [7:0] m0_datrd, m1_datrd, s_datwr, z_m0_datrd, z_m1_datrd, z_s_datwr;
    logic m0_ack, m1_ack, m0_err, m1_err, s_cyc, s_stb, s_we;
    logic z_m0_ack, z_m1_ack, z_m0_err, z_m1_err, z_s_cyc, z_s_stb, z_s_we;
    logic [3:0] s_adr, z_s_adr;
    logic [0:0] s_sel, z_s_sel;
    logic [1:0] gnt, z_gnt;
    int total = 0;
    int bad = 0;
    always #5 clock = ~clock;
    wb_bridge_arbiter #(.timeout_cycles(16)) dut (
        .clock(clock), .reset(reset),
        .m0_cyc(m0_cyc), .m1_cyc(m1_cyc), .m0_stb(m0_stb), .m1_stb(m1_stb),
        .m0_we(m0_we), .m1_we(m1_we), .m0_adr(m0_adr), .m1_adr(m1_adr),
        .m0_datwr(m0_datwr), .m1_datwr(m1_datwr), .m0_sel(m0_sel), .m1_sel(m1_sel),
        .m0_datrd(m0_datrd), .m1_datrd(m1_datrd), .m0_ack(m0_ack), .m1_ack(m1_ack),
        .m0_err(m0_err), .m1_err(m1_err), .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we),
        .s_adr(s_adr), .s_datwr(s_datwr), .s_sel(s_sel), .s_datrd(s_datrd),
        .s_ack(s_ack), .gnt(gnt)
    );
    wb_bridge_arbiter #(.timeout_cycles(0)) dut0 (
        .clock(clock), .reset(reset),
        .m0_cyc(m0_cyc), .m1_cyc(m1_cyc), .m0_stb(m0_stb), .m1_stb(m1_stb),
        .m0_we(m0_we), .m1_we(m1_we), .m0_adr(m0_adr), .m1_adr(m1_adr),
        .m0_datwr(m0_datwr), .m1_datwr(m1_datwr), .m0_sel(m0_sel), .m1_sel(m1_sel),
        .m0_datrd(z_m0_datrd), .m1_datrd(z_m1_datrd), .m0_ack(z_m0_ack), .m1_ack(z_m1_ack),
        .m0_err(z_m0_err), .m1_err(z_m1_err), .s_cyc(z_s_cyc), .s_stb(z_s_stb), .s_we(z_s_we),
        .s_adr(z_s_adr), .s_datwr(z_s_datwr), .s_sel(z_s_sel), .s_datrd(s_datrd),
        .s_ack(s_ack), .gnt(z_gnt)
    );
    // in = {m0_cyc, m0_stb, m1_cyc, m1_stb, s_ack}; ae = {m0_ack, m1_ack, m0_err, m1_err}; ctl = {s_cyc, s_stb, s_we}
    typedef struct packed {
        logic [4:0] in;
        logic [1:0] gnt;
        logic [3:0] ae;
        logic [2:0] ctl;
        logic [3:0] sadr;
        logic [7:0] d0;
        logic [7:0] d1;
    } vec_t;
    vec_t vt [22];
    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, got, exp);
        end
    endtask
    // drive one cycle of inputs at the falling edge, leave time to settle before checking
    task automatic next(input logic c0, s0, c1, s1, ack);
        @(negedge clock);
        reset = 1'b0;
        m0_cyc = c0; m0_stb = s0; m1_cyc = c1; m1_stb = s1; s_ack = ack;
        #2;
    endtask
    task automatic wait_err(output int n);
        n = 0;
        while (!m0_err && n < 40) begin
            n++;
            next(1, 1, 0, 0, 0);
        end
    endtask
    initial begin
        int n;
        int errs;
        vt = '{
            '{5'b00000, 2'b00, 4'b0000, 3'b000, 4'h0, 8'h00, 8'h00},
            '{5'b11110, 2'b00, 4'b0000, 3'b000, 4'h0, 8'h00, 8'h00},
            '{5'b11110, 2'b01, 4'b0000, 3'b110, 4'h3, 8'h5A, 8'h00},
            '{5'b11111, 2'b01, 4'b1000, 3'b110, 4'h3, 8'h5A, 8'h00},
            '{5'b00110, 2'b01, 4'b0000, 3'b000, 4'h3, 8'h5A, 8'h00},
            '{5'b00110, 2'b00, 4'b0000, 3'b000, 4'h0, 8'h00, 8'h00},
            '{5'b00110, 2'b10, 4'b0000, 3'b111, 4'hA, 8'h00, 8'h5A},
            '{5'b00001, 2'b10, 4'b0100, 3'b001, 4'hA, 8'h00, 8'h5A},
            '{5'b11110, 2'b00, 4'b0000, 3'b000, 4'h0, 8'h00, 8'h00},
            '{5'b11111, 2'b01, 4'b1000, 3'b110, 4'h3, 8'h5A, 8'h00},
            '{5'b00110, 2'b01, 4'b0000, 3'b000, 4'h3, 8'h5A, 8'h00},
            '{5'b11110, 2'b00, 4'b0000, 3'b000, 4'h0, 8'h00, 8'h00},
            '{5'b11110, 2'b10, 4'b0000, 3'b111, 4'hA, 8'h00, 8'h5A},
            '{5'b11111, 2'b10, 4'b0100, 3'b111, 4'hA, 8'h00, 8'h5A},
            '{5'b11100, 2'b10, 4'b0000, 3'b101, 4'hA, 8'h00, 8'h5A},
            '{5'b11111, 2'b10, 4'b0100, 3'b111, 4'hA, 8'h00, 8'h5A},
            '{5'b11111, 2'b10, 4'b0100, 3'b111, 4'hA, 8'h00, 8'h5A},
            '{5'b11000, 2'b10, 4'b0000, 3'b001, 4'hA, 8'h00, 8'h5A},
            '{5'b11000, 2'b00, 4'b0000, 3'b000, 4'h0, 8'h00, 8'h00},
            '{5'b11001, 2'b01, 4'b1000, 3'b110, 4'h3, 8'h5A, 8'h00},
            '{5'b00000, 2'b01, 4'b0000, 3'b000, 4'h3, 8'h5A, 8'h00},
            '{5'b00000, 2'b00, 4'b0000, 3'b000, 4'h0, 8'h00, 8'h00}
        };
        repeat (2) @(negedge clock);
        #2;
        chk("reset_state", {gnt, s_cyc, m0_err, m1_err}, 0);
        for (int i = 0; i < 22; i++) begin
            next(vt[i].in[4], vt[i].in[3], vt[i].in[2], vt[i].in[1], vt[i].in[0]);
            chk($sformatf("vec%0d", i),
                {gnt, m0_ack, m1_ack, m0_err, m1_err, s_cyc, s_stb, s_we, s_adr, m0_datrd, m1_datrd},
                {vt[i].gnt, vt[i].ae, vt[i].ctl, vt[i].sadr, vt[i].d0, vt[i].d1});
        end
        next(1, 1, 0, 0, 0);
        chk("tmo_idle_gnt", gnt, 2'b00);
        next(1, 1, 0, 0, 0);
        chk("tmo_busy", {gnt, s_datwr, m0_err}, {2'b01, 8'h11, 1'b0});
        wait_err(n);
        chk("tmo_err_cycle", n, 16);
        chk("drain_entry", {gnt, s_cyc, s_stb, m1_err}, {2'b01, 1'b1, 1'b0, 1'b0});
        next(0, 0, 1, 1, 0);
        chk("drain_hold", {gnt, s_cyc, s_stb, m0_err, s_adr}, {2'b01, 1'b1, 1'b0, 1'b0, 4'h0});
        next(0, 0, 0, 0, 1);
        chk("drain_late_ack", {m0_ack, m1_ack, s_cyc}, {1'b0, 1'b0, 1'b1});
        next(0, 0, 0, 0, 0);
        chk("drain_exit", {gnt, s_cyc}, 0);
        next(1, 1, 0, 0, 0);
        next(1, 1, 0, 0, 0);
        chk("rst_busy_pre", gnt, 2'b01);
        @(negedge clock);
        reset = 1'b1;
        next(1, 1, 1, 1, 0);
        chk("rst_busy_post", {gnt, s_cyc}, 0);
        next(0, 0, 0, 0, 0);
        chk("rst_busy_tie", gnt, 2'b01);
        next(0, 0, 0, 0, 0);
        next(1, 1, 0, 0, 0);
        next(1, 1, 0, 0, 0);
        wait_err(n);
        chk("rst_drain_pre", {gnt, s_cyc, s_stb, m0_err}, {2'b01, 1'b1, 1'b0, 1'b1});
        @(negedge clock);
        reset = 1'b1;
        next(1, 1, 1, 1, 0);
        chk("rst_drain_post", {gnt, s_cyc, m0_err}, 0);
        next(0, 0, 0, 0, 0);
        chk("rst_drain_tie", gnt, 2'b01);
        next(0, 0, 0, 0, 0);
        next(1, 1, 0, 0, 0);
        errs = 0;
        for (int i = 0; i < 5000; i++) begin
            next(1, 1, 0, 0, 0);
            errs += int'(z_m0_err | z_m1_err);
        end
        chk("stall_no_err", errs, 0);
        chk("stall_gnt", {z_gnt, z_s_cyc, z_s_stb}, {2'b01, 1'b1, 1'b1});
        next(1, 1, 0, 0, 1);
        chk("stall_ack", {z_m0_ack, z_m0_datrd, z_m1_ack}, {1'b1, 8'h5A, 1'b0});
        next(0, 0, 0, 0, 0);
        next(0, 0, 0, 0, 0);
        chk("stall_idle", {z_gnt, z_s_cyc}, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
